// File: rtl/sequential_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Handles unsigned and two's-complement signed operands; signed results truncate toward zero.
module sequential_divider #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic             signed_r;
  logic             a_neg_r;
  logic             q_neg_r;
  logic             ovf_pend_r;

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH-1:0] diff_s;
  logic             trial_ok_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
  logic             b_zero_s;
  logic             ovf_case_s;

  // Two's-complement negation modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude read as an unsigned WIDTH-bit value, so the most-negative pattern maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          if (b_zero_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_r == CW'(1)) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FIX:  state_next_s = ST_DONE;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Trial subtraction and sign correction of the final result.
  always_comb begin
    b_zero_s    = (OperandB == {WIDTH{1'b0}});
    ovf_case_s  = Signed && (OperandA == {1'b1, {(WIDTH-1){1'b0}}}) && (OperandB == {WIDTH{1'b1}});
    rem_shift_s = {rem_r, dvd_r[WIDTH-1]};
    // The compare needs the carried-out bit; the difference itself always fits WIDTH bits.
    trial_ok_s  = (rem_shift_s >= {1'b0, dsr_r});
    diff_s      = rem_shift_s[WIDTH-1:0] - dsr_r;
    if (signed_r && q_neg_r) begin
      q_fix_s = negate(dvd_r);
    end else begin
      q_fix_s = dvd_r;
    end
    if (signed_r && a_neg_r) begin
      r_fix_s = negate(rem_r);
    end else begin
      r_fix_s = rem_r;
    end
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_r    <= {CW{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      dvd_r      <= {WIDTH{1'b0}};
      dsr_r      <= {WIDTH{1'b0}};
      signed_r   <= 1'b0;
      a_neg_r    <= 1'b0;
      q_neg_r    <= 1'b0;
      ovf_pend_r <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Quotient   <= {WIDTH{1'b0}};
      Remainder  <= {WIDTH{1'b0}};
      DivByZero  <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            signed_r   <= Signed;
            a_neg_r    <= Signed & OperandA[WIDTH-1];
            q_neg_r    <= Signed & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            ovf_pend_r <= ovf_case_s;
            dvd_r      <= magnitude(OperandA, Signed);
            dsr_r      <= magnitude(OperandB, Signed);
            rem_r      <= {WIDTH{1'b0}};
            count_r    <= CW'(WIDTH);
            Overflow   <= 1'b0;
            // Divide-by-zero finishes on the accepting edge, so Busy never rises.
            if (b_zero_s) begin
              Busy      <= 1'b0;
              Done      <= 1'b1;
              DivByZero <= 1'b1;
              Quotient  <= {WIDTH{1'b1}};
              Remainder <= OperandA;
            end else begin
              Busy      <= 1'b1;
              Done      <= 1'b0;
              DivByZero <= 1'b0;
            end
          end else begin
            Done <= 1'b0;
          end
        end
        ST_RUN: begin
          if (trial_ok_s) begin
            rem_r <= diff_s;
          end else begin
            rem_r <= rem_shift_s[WIDTH-1:0];
          end
          dvd_r   <= {dvd_r[WIDTH-2:0], trial_ok_s};
          count_r <= count_r - CW'(1);
        end
        ST_FIX: begin
          Quotient  <= q_fix_s;
          Remainder <= r_fix_s;
          Overflow  <= ovf_pend_r;
          Busy      <= 1'b0;
          Done      <= 1'b1;
        end
        ST_DONE: begin
          Done <= 1'b0;
        end
        default: begin
          Busy <= 1'b0;
          Done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed corner cases plus random operands
// compared against an integer-arithmetic reference model.
module tb_sequential_divider;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        Signed;
  logic [15:0] OperandA;
  logic [15:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        DivByZero;
  logic        Overflow;

  int          tests;
  int          fails;
  logic [15:0] prev_q;
  logic [15:0] prev_r;

  sequential_divider #(.WIDTH(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Signed    (Signed),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .Overflow  (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, SV truncates toward zero and % follows the dividend.
  function automatic void model(input logic s, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic ov);
    int sa;
    int sb;
    if (b == 16'h0000) begin
      q = 16'hFFFF; r = a; dz = 1'b1; ov = 1'b0;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
      dz = 1'b0;
      ov = (sa == -32768) && (sb == -1);
    end else begin
      q = a / b; r = a % b; dz = 1'b0; ov = 1'b0;
    end
  endfunction

  task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b);
    @(negedge Clock);
    Start = 1'b1; Signed = s; OperandA = a; OperandB = b;
    @(posedge Clock);
    #1 Start = 1'b0;
  endtask

  // Called just after the accepting edge; follows the request to Done and checks everything.
  task automatic wait_done(input logic s, input logic [15:0] a, input logic [15:0] b,
                           input int inject, input bit b2b,
                           input logic ns, input logic [15:0] na, input logic [15:0] nb);
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    logic        eov;
    int          lat;
    bit          got;
    model(s, a, b, eq, er, edz, eov);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Done) begin
        got = 1'b1;
        break;
      end
      chk("busy_run", Busy, 1);
      chk("hold_q", Quotient, prev_q);
      chk("hold_r", Remainder, prev_r);
      chk("flags_clr", {DivByZero, Overflow}, 0);
      if (lat == inject) begin
        Start = 1'b1; Signed = 1'b0; OperandA = 16'd9; OperandB = 16'd3;
      end
      @(posedge Clock);
      lat++;
      #1 Start = 1'b0;
    end
    if (b2b) begin
      Start = 1'b1; Signed = ns; OperandA = na; OperandB = nb;
    end
    chk("done_seen", got, 1);
    chk("latency", lat, (b == 16'h0000) ? 1 : 18);
    chk("busy_at_done", Busy, 0);
    chk("quotient", Quotient, eq);
    chk("remainder", Remainder, er);
    chk("divbyzero", DivByZero, edz);
    chk("overflow", Overflow, eov);
    prev_q = eq;
    prev_r = er;
    @(negedge Clock);
    chk("done_pulse", Done, 0);
    chk("busy_after", Busy, 0);
    chk("q_stable", Quotient, eq);
  endtask

  task automatic run(input logic s, input logic [15:0] a, input logic [15:0] b);
    issue(s, a, b);
    wait_done(s, a, b, -1, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    logic        rs;
    logic [15:0] ra;
    logic [15:0] rb;
    tests = 0; fails = 0;
    prev_q = 16'h0; prev_r = 16'h0;
    Clock = 1'b0; Reset = 1'b1; Start = 1'b0; Signed = 1'b0;
    OperandA = 16'h0; OperandB = 16'h0;

    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_dz", DivByZero, 0);
    chk("rst_ov", Overflow, 0);
    Reset = 1'b0;

    run(1'b0, 16'd100, 16'd7);
    run(1'b1, 16'hFFF9, 16'h0002);
    run(1'b1, 16'h0007, 16'hFFFE);
    run(1'b1, 16'h8000, 16'hFFFF);
    run(1'b0, 16'h8000, 16'hFFFF);
    run(1'b0, 16'h1234, 16'h0000);
    run(1'b1, 16'h1234, 16'h0000);
    run(1'b1, 16'h8000, 16'h0000);

    // Start pulsed mid-RUN must be neither honoured nor queued.
    issue(1'b0, 16'hFFFF, 16'h0001);
    wait_done(1'b0, 16'hFFFF, 16'h0001, 5, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("no_queue_busy", Busy, 0);
      chk("no_queue_done", Done, 0);
    end

    // Back-to-back: Start held through the Done cycle is taken one edge after DONE.
    issue(1'b0, 16'd50, 16'd5);
    wait_done(1'b0, 16'd50, 16'd5, -1, 1'b1, 1'b1, 16'hFF9C, 16'd7);
    @(posedge Clock);
    #1 Start = 1'b0;
    wait_done(1'b1, 16'hFF9C, 16'd7, -1, 1'b0, 1'b0, 16'h0, 16'h0);

    // Reset in the middle of RUN aborts with no Done.
    issue(1'b0, 16'd1000, 16'd10);
    repeat (8) @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_q", Quotient, 0);
    chk("abort_r", Remainder, 0);
    chk("abort_dz", DivByZero, 0);
    chk("abort_ov", Overflow, 0);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    prev_q = 16'h0; prev_r = 16'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      chk("abort_no_done", Done, 0);
      chk("abort_idle", Busy, 0);
    end
    run(1'b0, 16'd1000, 16'd10);

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'hFFFF;
        2:       rb = 16'h0001;
        3:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      run(rs, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
